// File: rtl/imem_dport_arb.sv
// Arbiter for the imem shared data-read port: CPU loads (priority) and host/debug reads
// (anti-starvation force-grant plus locked bursts). Grants are combinational, responses one cycle later.
module imem_dport_arb #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_lock_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic [ADDR_W-1:0] daddr_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              dbg_burst
);

  // Handshake: a requester holds req/addr stable until its gnt is seen high in the
  // same cycle; the matching rvalid/rdata arrive exactly one cycle after that grant.

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_e;

  state_e            state;
  logic [3:0]        starve_cnt;
  logic [7:0]        beat_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              rvalid_q;
  logic              owner_q;   // 1: the response in flight belongs to the host

  always_comb begin
    cpu_gnt_o  = 1'b0;
    host_gnt_o = 1'b0;
    if (!rst) begin
      if (state == BURST) begin
        host_gnt_o = host_req_i;
      end else if (cpu_req_i && (starve_cnt < STARVE_LIM)) begin
        cpu_gnt_o = 1'b1;
      end else begin
        host_gnt_o = host_req_i;
      end
    end
  end

  // Idle cycles replay the last granted address so the imem port does not toggle.
  always_comb begin
    if (rst)             daddr_o = '0;
    else if (cpu_gnt_o)  daddr_o = cpu_addr_i;
    else if (host_gnt_o) daddr_o = host_addr_i;
    else                 daddr_o = last_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      last_addr  <= '0;
      rvalid_q   <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      rvalid_q <= cpu_gnt_o | host_gnt_o;
      owner_q  <= host_gnt_o;
      if (cpu_gnt_o || host_gnt_o) last_addr <= daddr_o;

      if (host_gnt_o || !host_req_i) starve_cnt <= '0;
      else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;

      case (state)
        ARB: begin
          if (host_gnt_o && host_lock_i && (BURST_MAX > 1)) begin
            state    <= BURST;
            beat_cnt <= 8'd1;
          end
        end
        BURST: begin
          if (host_gnt_o) beat_cnt <= beat_cnt + 8'd1;
          if (!host_req_i || !host_lock_i || (beat_cnt >= BURST_LIM - 8'd1))
            state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Gating with rst drops a response whose grant was immediately followed by reset.
  assign cpu_rvalid_o  = rvalid_q & ~owner_q & ~rst;
  assign host_rvalid_o = rvalid_q &  owner_q & ~rst;
  assign cpu_rdata_o   = cpu_rvalid_o  ? data_i : '0;
  assign host_rdata_o  = host_rvalid_o ? data_i : '0;
  assign dbg_burst     = (state == BURST);

endmodule

// File: tb/tb_imem_dport_arb.sv
// Bench for imem_dport_arb: directed scenarios then randomized traffic, checked by a
// rule-level reference model and per-port expected-response queues.
module tb_imem_dport_arb;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req_i = 1'b0;
  logic [ADDR_W-1:0] cpu_addr_i = '0;
  logic              cpu_gnt_o, cpu_rvalid_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              host_req_i = 1'b0;
  logic              host_lock_i = 1'b0;
  logic [ADDR_W-1:0] host_addr_i = '0;
  logic              host_gnt_o, host_rvalid_o;
  logic [DATA_W-1:0] host_rdata_o;
  logic [ADDR_W-1:0] daddr_o;
  logic [DATA_W-1:0] data_i = '0;
  logic              dbg_burst;

  imem_dport_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .host_req_i(host_req_i), .host_lock_i(host_lock_i), .host_addr_i(host_addr_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .daddr_o(daddr_o), .data_i(data_i), .dbg_burst(dbg_burst)
  );

  // clock / reset / memory
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[16] = 32'hDEADBEEF;
  end
  always @(negedge clk) data_i = mem[daddr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // scoreboard queues
  logic [DATA_W-1:0] cpu_exp_q[$];
  int                cpu_cyc_q[$];
  logic [DATA_W-1:0] host_exp_q[$];
  int                host_cyc_q[$];

  // reference model state
  bit              m_burst  = 0;
  int              m_starve = 0;
  int              m_beats  = 0;
  logic [ADDR_W-1:0] m_last = '0;

  // driver: one cycle of stimulus, grant/address checks and expectation push
  task automatic step(input logic r, input logic c, input logic [ADDR_W-1:0] ca,
                      input logic h, input logic l, input logic [ADDR_W-1:0] ha,
                      output logic gc, output logic gh, output logic ec, output logic eh);
    logic [ADDR_W-1:0] ea;
    @(posedge clk);
    #1;
    rst = r; cpu_req_i = c; cpu_addr_i = ca; host_req_i = h; host_lock_i = l; host_addr_i = ha;
    #2;
    if (r) begin
      ec = 0; eh = 0; ea = '0;
      m_burst = 0; m_starve = 0; m_beats = 0; m_last = '0;
      cpu_exp_q.delete(); cpu_cyc_q.delete(); host_exp_q.delete(); host_cyc_q.delete();
    end else begin
      if (m_burst) begin
        ec = 0; eh = h;
      end else begin
        ec = c && (m_starve < STARVE_MAX);
        eh = !ec && h;
      end
      ea = ec ? ca : (eh ? ha : m_last);
      if (ec || eh) m_last = ea;
      if (m_burst) begin
        if (eh) m_beats++;
        if (!h || (eh && !l) || m_beats >= BURST_MAX) m_burst = 0;
      end else if (eh && l && BURST_MAX > 1) begin
        m_burst = 1; m_beats = 1;
      end
      m_starve = (h && !eh) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
      if (ec) begin cpu_exp_q.push_back(mem[ca]);  cpu_cyc_q.push_back(cyc);  end
      if (eh) begin host_exp_q.push_back(mem[ha]); host_cyc_q.push_back(cyc); end
    end
    chk("cpu_gnt",  32'(cpu_gnt_o),  32'(ec));
    chk("host_gnt", 32'(host_gnt_o), 32'(eh));
    chk("daddr",    32'(daddr_o),    32'(ea));
    gc = cpu_gnt_o; gh = host_gnt_o;
  endtask

  // monitor: responses due from last cycle's grants must appear now, on the right port
  always @(posedge clk) begin
    bit due;
    #4;
    due = (cpu_cyc_q.size() > 0) && (cpu_cyc_q[0] == cyc - 1);
    chk("cpu_rvalid", 32'(cpu_rvalid_o), 32'(due));
    if (due) begin
      void'(cpu_cyc_q.pop_front());
      chk("cpu_rdata", cpu_rdata_o, cpu_exp_q.pop_front());
    end else chk("cpu_rdata_idle", cpu_rdata_o, 32'h0);
    due = (host_cyc_q.size() > 0) && (host_cyc_q[0] == cyc - 1);
    chk("host_rvalid", 32'(host_rvalid_o), 32'(due));
    if (due) begin
      void'(host_cyc_q.pop_front());
      chk("host_rdata", host_rdata_o, host_exp_q.pop_front());
    end else chk("host_rdata_idle", host_rdata_o, 32'h0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gc, gh, ec, eh;
    int cc, hc, hg, cg;
    logic cr, hr, hl;
    logic [ADDR_W-1:0] ca, ha;

    // reset with both requesting, then CPU alone at 0x0010
    repeat (3) step(1, 1, 14'h0010, 1, 0, 14'h0020, gc, gh, ec, eh);
    chk("reset_daddr", 32'(daddr_o), 32'h0);
    step(0, 1, 14'h0010, 0, 0, 14'h0020, gc, gh, ec, eh);
    chk("first_cpu_gnt", 32'(gc), 32'h1);
    step(0, 0, 14'h0010, 0, 0, 14'h0020, gc, gh, ec, eh);
    chk("cpu_resp_data", cpu_rdata_o, 32'hDEADBEEF);

    // both continuously requesting: 4 CPU grants then 1 host grant, repeating
    cc = 0; hc = 0; hg = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 14'(14'h200 + cc), 1, 0, 14'(14'h300 + hc), gc, gh, ec, eh);
      if (ec) cc++;
      if (eh) hc++;
      if (gh) hg++;
      if (i == 5) chk("fifth_is_host", 32'(gh), 32'h1);
    end
    chk("host_share_4to1", 32'(hg), 32'd4);
    step(0, 0, '0, 0, 0, '0, gc, gh, ec, eh);

    // locked burst 0x100.., CPU requesting from the second cycle
    hc = 0; hg = 0; cg = 0;
    for (int i = 1; i <= 13; i++) begin
      step(0, i > 1, 14'h0400, 1, i <= 8, 14'(14'h100 + hc), gc, gh, ec, eh);
      if (eh) hc++;
      if (i <= 8 && gh) hg++;
      if (i <= 8 && gc) cg++;
      if (i == 9) chk("cpu_after_burst", 32'(gc), 32'h1);
      if (i == 9) cc = 0;
      if (i > 9 && ec) cc++;
      if (i == 13) chk("host_after_starve", 32'(gh), 32'h1);
    end
    chk("burst_host_beats", 32'(hg), 32'd8);
    chk("burst_cpu_blocked", 32'(cg), 32'd0);
    step(0, 0, '0, 0, 0, '0, gc, gh, ec, eh);

    // lock dropped on the 3rd beat
    for (int i = 1; i <= 4; i++) begin
      step(0, i > 1, 14'h0500, i <= 3, i < 3, 14'(14'h180 + i), gc, gh, ec, eh);
      if (i == 3) chk("beat3_host", 32'(gh), 32'h1);
      if (i == 4) chk("cpu_after_drop", 32'(gc), 32'h1);
    end

    // reset right after a CPU grant: the response must be dropped
    step(0, 1, 14'h0777, 0, 0, '0, gc, gh, ec, eh);
    step(1, 0, '0, 0, 0, '0, gc, gh, ec, eh);
    step(0, 0, '0, 0, 0, '0, gc, gh, ec, eh);
    chk("no_rvalid_after_rst", 32'(cpu_rvalid_o), 32'h0);

    // randomized traffic respecting hold-until-granted
    cr = 0; hr = 0; hl = 0; ca = '0; ha = '0; ec = 0; eh = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      int dens;
      dens = (i / 500) % 3;
      r = ($urandom_range(0, 299) == 0);
      if (!(cr && !ec)) begin
        cr = ($urandom_range(0, 3) < 1 + dens);
        ca = 14'($urandom_range(0, (1 << ADDR_W) - 1));
      end
      if (!(hr && !eh)) begin
        hr = ($urandom_range(0, 3) < 1 + dens);
        ha = 14'($urandom_range(0, (1 << ADDR_W) - 1));
      end
      hl = ($urandom_range(0, 3) != 0);
      step(r, cr, ca, hr, hl, ha, gc, gh, ec, eh);
    end
    step(0, 0, '0, 0, 0, '0, gc, gh, ec, eh);
    step(0, 0, '0, 0, 0, '0, gc, gh, ec, eh);
    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
